// File: rtl/btn_reader_pkg.sv
// Shared definitions for the push-button reader: channel FSM state encoding
// and default timing constants.
package btn_reader_pkg;

  // Debounce channel states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_PRESS_WAIT = 2'b01,
    ST_HELD       = 2'b10,
    ST_REL_WAIT   = 2'b11
  } btn_state_e;

  // Default timing: clk cycles per tick, ticks to accept a change, ticks to long-press
  localparam int unsigned DEF_TICK_DIV     = 500_000;
  localparam int unsigned DEF_STABLE_TICKS = 4;
  localparam int unsigned DEF_LONG_TICKS   = 100;

endpackage

// File: rtl/btn_debounce_ch.sv
// Single-button debounce channel: 2-flop synchroniser, tick-driven debounce
// FSM, and hold counter for long-press detection.
// Ports:
//   clk, rst   - clock, async active-low reset
//   i_tick     - shared sampling tick (one clk wide)
//   i_btn      - raw asynchronous button, 1 = pressed
//   o_level    - debounced level
//   o_press    - 1-cycle pulse on accepted press
//   o_release  - 1-cycle pulse on accepted release
//   o_long     - 1-cycle pulse when the hold reaches LONG_TICKS
module btn_debounce_ch
  import btn_reader_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned CNT_W  = $clog2(STABLE_TICKS);
  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

  btn_state_e        r_state, w_state_nxt;
  logic [1:0]        r_sync;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_level, r_press, r_release, r_long;
  logic              w_level_nxt, w_press_nxt, w_release_nxt, w_long_nxt;
  logic              w_sample;

  assign w_sample  = r_sync[1];
  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

  // State, counters, synchroniser and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync    <= '0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hold    <= w_hold_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
    end
  end

  // Next-state and pulse decode; everything holds between ticks
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hold_nxt    = r_hold;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    if (i_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_sample) begin
            w_state_nxt = ST_PRESS_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_sample) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(STABLE_TICKS - 1)) begin
            w_state_nxt = ST_HELD;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
            w_hold_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (w_sample) begin
            // Saturating hold; long fires only on the step that reaches LONG_TICKS
            if (r_hold < HOLD_W'(LONG_TICKS)) begin
              w_hold_nxt = r_hold + HOLD_W'(1);
              w_long_nxt = (r_hold == HOLD_W'(LONG_TICKS - 1));
            end
          end else begin
            w_state_nxt = ST_REL_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_REL_WAIT: begin
          // A bounce back to 1 resumes the hold without advancing it
          if (w_sample) begin
            w_state_nxt = ST_HELD;
          end else if (r_cnt == CNT_W'(STABLE_TICKS - 1)) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/btn_reader.sv
// Debounced push-button reader: shared sampling prescaler, one debounce
// channel per button, and a press aggregator.
// Ports:
//   clk, rst     - clock, async active-low reset
//   btn_in       - raw buttons, 1 = pressed
//   btn_level    - debounced level per button
//   btn_press    - 1-cycle pulse per accepted press
//   btn_release  - 1-cycle pulse per accepted release
//   btn_long     - 1-cycle pulse when a hold reaches LONG_TICKS
//   press_any    - OR of btn_press
//   last_idx     - lowest index pressed in the most recent press cycle
//   press_count  - press cycles seen, modulo 256
module btn_reader
  import btn_reader_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             press_any,
  output logic [IDX_W-1:0] last_idx,
  output logic [7:0]       press_count
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);

  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;
  logic [IDX_W-1:0]   r_last_idx, w_low_idx;
  logic [7:0]         r_press_count;

  // Sampling prescaler: tick on the terminal count
  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRESC_W'(1);
  end

  // One debounce channel per button
  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (w_tick),
      .i_btn     (btn_in[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_long    (btn_long[g])
    );
  end

  // Pure OR of registered pulses, so it lines up with btn_press
  assign press_any = |btn_press;

  // Lowest set index wins when several buttons press together
  always_comb begin
    w_low_idx = '0;
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (btn_press[i]) w_low_idx = IDX_W'(i);
    end
  end

  // Aggregator: one count per press cycle regardless of how many buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_idx    <= '0;
      r_press_count <= '0;
    end else if (press_any) begin
      r_last_idx    <= w_low_idx;
      r_press_count <= r_press_count + 8'd1;
    end
  end

  assign last_idx    = r_last_idx;
  assign press_count = r_press_count;

endmodule

// File: tb/tb_btn_reader.sv
// Self-checking bench for btn_reader using a run-length reference model.
module tb_btn_reader;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LONG_TICKS   = 6;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;
  logic       press_any;
  logic [1:0] last_idx;
  logic [7:0] press_count;

  int n_checks;
  int n_fail;

  btn_reader #(
    .N_BTN        (4),
    .IDX_W        (2),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .LONG_TICKS   (LONG_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .press_any   (press_any),
    .last_idx    (last_idx),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted level plus the length of the current run of
  // samples that disagree with it; hold counts agreeing ticks while pressed.
  logic [3:0] m_s1, m_s2, m_level;
  int         m_div;
  int         m_run [4];
  int         m_hold [4];
  logic [3:0] e_press, e_release, e_long;
  logic [1:0] e_idx;
  logic [7:0] e_cnt;

  logic [26:0] w_dut, w_exp;
  assign w_dut = {btn_level, btn_press, btn_release, btn_long, press_any, last_idx, press_count};
  assign w_exp = {m_level, e_press, e_release, e_long, |e_press, e_idx, e_cnt};

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_div = 0;
    e_press = '0; e_release = '0; e_long = '0; e_idx = '0; e_cnt = '0;
    for (int b = 0; b < 4; b++) begin
      m_run[b]  = 0;
      m_hold[b] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] old_press;
    logic       tick;
    logic       s;
    if (!rst) begin
      model_reset();
      return;
    end
    old_press = e_press;
    tick      = (m_div == TICK_DIV - 1);
    e_press = '0; e_release = '0; e_long = '0;
    if (tick) begin
      for (int b = 0; b < 4; b++) begin
        s = m_s2[b];
        if (!m_level[b]) begin
          if (s) begin
            m_run[b]++;
            if (m_run[b] == STABLE_TICKS) begin
              m_level[b] = 1'b1; e_press[b] = 1'b1; m_run[b] = 0; m_hold[b] = 0;
            end
          end else m_run[b] = 0;
        end else begin
          if (!s) begin
            m_run[b]++;
            if (m_run[b] == STABLE_TICKS) begin
              m_level[b] = 1'b0; e_release[b] = 1'b1; m_run[b] = 0;
            end
          end else begin
            if (m_run[b] == 0 && m_hold[b] < LONG_TICKS) begin
              m_hold[b]++;
              if (m_hold[b] == LONG_TICKS) e_long[b] = 1'b1;
            end
            m_run[b] = 0;
          end
        end
      end
    end
    if (|old_press) begin
      for (int b = 3; b >= 0; b--) if (old_press[b]) e_idx = 2'(b);
      e_cnt = e_cnt + 8'd1;
    end
    m_s2  = m_s1;
    m_s1  = btn_in;
    m_div = (m_div + 1) % TICK_DIV;
  endtask

  // Drive one cycle: inputs change at negedge, model steps at posedge, return at negedge
  task automatic step(input logic [3:0] v);
    btn_in = v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'hF);
      n_checks++;
      if (w_dut !== 27'd0) begin
        n_fail++; $display("FAIL reset_hold cyc %0d: got %h want 0", i, w_dut);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(4'h0);
      n_checks++;
      if (w_dut !== w_exp || (btn_press | btn_release | btn_long) !== 4'h0) begin
        n_fail++; $display("FAIL reset_idle cyc %0d: got %h want %h", i, w_dut, w_exp);
      end
    end
  endtask

  task automatic test_clean_press();
    int np = 0, nr = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0100);
      n_checks++;
      if (w_dut !== w_exp) begin
        n_fail++; $display("FAIL clean_press cyc %0d: got %h want %h", i, w_dut, w_exp);
      end
      if (btn_press[2]) np++;
    end
    n_checks++;
    if (np !== 1 || btn_level[2] !== 1'b1 || last_idx !== 2'd2 || press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL clean_press_state: np=%0d lvl=%b idx=%0d cnt=%0d want 1 1 2 1",
               np, btn_level[2], last_idx, press_count);
    end
    for (int i = 0; i < 40; i++) begin
      step(4'b0000);
      n_checks++;
      if (w_dut !== w_exp) begin
        n_fail++; $display("FAIL clean_release cyc %0d: got %h want %h", i, w_dut, w_exp);
      end
      if (btn_release[2]) nr++;
    end
    n_checks++;
    if (nr !== 1 || btn_level[2] !== 1'b0) begin
      n_fail++; $display("FAIL clean_release_state: nr=%0d lvl=%b want 1 0", nr, btn_level[2]);
    end
  endtask

  task automatic test_glitch();
    int np = 0, nr = 0, dur;
    for (int i = 0; i < 36; i++) begin
      step((i < 6) ? 4'b0001 : 4'b0000);
      n_checks++;
      if (w_dut !== w_exp) begin
        n_fail++; $display("FAIL glitch_press cyc %0d: got %h want %h", i, w_dut, w_exp);
      end
      if (btn_press[0]) np++;
    end
    n_checks++;
    if (np !== 0 || btn_level[0] !== 1'b0) begin
      n_fail++; $display("FAIL glitch_press_state: np=%0d lvl=%b want 0 0", np, btn_level[0]);
    end
    for (int i = 0; i < 30; i++) step(4'b0001);
    dur = int'($urandom_range(1, 6));
    for (int i = 0; i < dur + 30; i++) begin
      step((i < dur) ? 4'b0000 : 4'b0001);
      n_checks++;
      if (w_dut !== w_exp || btn_level[0] !== 1'b1) begin
        n_fail++; $display("FAIL glitch_release cyc %0d dur %0d: got %h want %h", i, dur, w_dut, w_exp);
      end
      if (btn_release[0]) nr++;
    end
    n_checks++;
    if (nr !== 0) begin
      n_fail++; $display("FAIL glitch_release_count: got %0d want 0", nr);
    end
    for (int i = 0; i < 40; i++) step(4'b0000);
  endtask

  task automatic test_long_press();
    int pt = -1, lt = -1, nl = 0;
    for (int i = 0; i < 50; i++) begin
      step(4'b0010);
      n_checks++;
      if (w_dut !== w_exp) begin
        n_fail++; $display("FAIL long_press cyc %0d: got %h want %h", i, w_dut, w_exp);
      end
      if (btn_press[1]) pt = i;
      if (btn_long[1]) begin nl++; lt = i; end
    end
    n_checks++;
    if (nl !== 1 || (lt - pt) !== LONG_TICKS * TICK_DIV) begin
      n_fail++; $display("FAIL long_once: pulses=%0d gap=%0d want 1 %0d", nl, lt - pt, LONG_TICKS * TICK_DIV);
    end
    for (int i = 0; i < 40; i++) begin
      step(4'b0000);
      n_checks++;
      if (w_dut !== w_exp || btn_long[1] !== 1'b0) begin
        n_fail++; $display("FAIL long_release cyc %0d: got %h want %h", i, w_dut, w_exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    int nb = 0;
    logic [7:0] c0;
    c0 = e_cnt;
    for (int i = 0; i < 30; i++) begin
      step(4'b1010);
      n_checks++;
      if (w_dut !== w_exp) begin
        n_fail++; $display("FAIL simul cyc %0d: got %h want %h", i, w_dut, w_exp);
      end
      if (btn_press == 4'b1010) nb++;
    end
    n_checks++;
    if (nb !== 1 || last_idx !== 2'd1 || press_count !== c0 + 8'd1) begin
      n_fail++; $display("FAIL simul_state: nb=%0d idx=%0d cnt=%0d want 1 1 %0d", nb, last_idx, press_count, c0 + 8'd1);
    end
    for (int i = 0; i < 40; i++) step(4'b0000);
  endtask

  task automatic test_back_to_back();
    logic [3:0] v;
    int len;
    for (int s = 0; s < 60; s++) begin
      v   = 4'($urandom_range(0, 15));
      len = int'($urandom_range(1, 30));
      for (int i = 0; i < len; i++) begin
        step(v);
        n_checks++;
        if (w_dut !== w_exp) begin
          n_fail++; $display("FAIL random seg %0d cyc %0d in %b: got %h want %h", s, i, v, w_dut, w_exp);
        end
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(4'b0000);
      n_checks++;
      if (w_dut !== w_exp) begin
        n_fail++; $display("FAIL random_drain cyc %0d: got %h want %h", i, w_dut, w_exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(m_run[3] > 0 && !m_level[3]) && guard < 50) begin
      step(4'b1000);
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_fail++; $display("FAIL reset_mid_reach: no debounce start in %0d cycles", guard);
    end
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (w_dut !== 27'd0) begin
      n_fail++; $display("FAIL reset_mid_async: got %h want 0", w_dut);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(4'b1000);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(4'b0000);
      n_checks++;
      if (w_dut !== 27'd0) begin
        n_fail++; $display("FAIL reset_mid_after cyc %0d: got %h want 0", i, w_dut);
      end
    end
  endtask

  task automatic test_wrap();
    int np = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 40; i++) begin
        step((i < 20) ? 4'b0001 : 4'b0000);
        n_checks++;
        if (w_dut !== w_exp) begin
          n_fail++; $display("FAIL wrap p %0d cyc %0d: got %h want %h", p, i, w_dut, w_exp);
        end
        if (btn_press[0]) np++;
      end
    end
    n_checks++;
    if (np !== 256 || press_count !== 8'd0) begin
      n_fail++; $display("FAIL wrap_final: presses=%0d cnt=%0d want 256 0", np, press_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    btn_in   = 4'hF;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
